ping_pong_row_buffer: RTL and testbench
=======================================

Name: ping_pong_row_buffer

Overview:
- Dual-bank (ping/pong) row memory for the convolution datapath.
- Directly consumes the four write/read enables produced by the ping-pong control FSM.
- While one bank is read toward the convolution window, the other bank stores the incoming pixel stream.
- Each bank has independent auto-incrementing write and read pointers, a registered single-cycle read path and protocol-error detection.

Parameters:
- IMAGE_SIZE, 16, pixels per row; this is the depth of each bank.
- DATA_SIZE, 16, pixel word width (half-precision: 1 sign + EXP_SIZE + MANT_SIZE).
- ADDR_SIZE, 4, pointer width; must satisfy 2^ADDR_SIZE >= IMAGE_SIZE.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-low.
- frame_start, input, 1, synchronous clear of all four pointers and of collision_err.
- din, input, DATA_SIZE, incoming pixel, sampled on a write.
- ping_wr_en, input, 1, write din into the ping bank.
- pong_wr_en, input, 1, write din into the pong bank.
- ping_rd_en, input, 1, read the next ping word.
- pong_rd_en, input, 1, read the next pong word.
- dout, output, DATA_SIZE, registered read data.
- dout_valid, output, 1, dout holds data from a read issued the previous cycle.
- dout_sel, output, 1, source bank of dout: 0 = ping, 1 = pong.
- ping_wr_ptr, output, ADDR_SIZE, current ping write pointer.
- pong_wr_ptr, output, ADDR_SIZE, current pong write pointer.
- collision_err, output, 1, sticky protocol-error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - All pointers = 0; dout = 0, dout_valid = 0, dout_sel = 0, collision_err = 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts any in-flight read: dout_valid is 0 in the first cycle after reset release.
- Storage: two arrays, each IMAGE_SIZE x DATA_SIZE.
- Write (per bank, every rising edge):
  - If wr_en is high: mem[wr_ptr] <= din.
  - wr_ptr increments; on reaching IMAGE_SIZE-1 it wraps to 0.
  - Both banks may be written in the same cycle with the same din; each bank then advances its own pointer.
- Read (every rising edge):
  - If ping_rd_en: dout <= ping_mem[ping_rd_ptr], dout_sel <= 0, dout_valid <= 1, ping_rd_ptr advances with the same wrap rule.
  - Else if pong_rd_en: same action on the pong bank with dout_sel <= 1.
  - Else: dout_valid <= 0 and dout holds its last value.
- Read latency: exactly 1 cycle from the rd_en edge to dout/dout_valid.
- Read-during-write, same bank, same address: read-first, so dout returns the old contents and the new data is stored.
- Simultaneous ping_rd_en and pong_rd_en:
  - Ping wins.
  - pong_rd_ptr does not advance.
  - collision_err <= 1.
- A write and a read enabled on the same bank in one cycle is legal; this is the normal streaming mode. The pointers are independent.
- collision_err is sticky: cleared only by rst or frame_start.
- frame_start:
  - Takes priority over the enables for pointer updates. All pointers go to 0 on that edge, and no pointer advances that cycle.
  - Writes and reads enabled in the same cycle still act at the pre-clear pointer values.
  - dout/dout_valid behave normally.
- Pointer arithmetic is ADDR_SIZE-bit unsigned. Wrap is at IMAGE_SIZE-1, not at 2^ADDR_SIZE-1. Valid IMAGE_SIZE range is 2..2^ADDR_SIZE.
- No flow control and no full/empty flags. Overwriting unread data is legal and is governed by the upstream controller's schedule.
- Target implementation: about 150-250 lines of RTL.

Test Plan:
- Linear write/read:
  - Stimulus: reset, then ping_wr_en for 16 cycles with din = 0x3C00+i, then ping_rd_en for 16 cycles.
  - Required: dout = 0x3C00..0x3C0F, one cycle after each rd_en; dout_valid high for exactly 16 cycles; dout_sel = 0.
- Wrap:
  - Stimulus: write 18 words (din = i) to pong, then read 2.
  - Required: pong_wr_ptr = 2 after the writes; reads return 16 and 17.
- Read collision:
  - Stimulus: ping_rd_en = pong_rd_en = 1 for one cycle.
  - Required: dout from ping, dout_sel = 0, pong_rd_ptr unchanged, collision_err = 1 and held until frame_start.
- Read-during-write:
  - Stimulus: ping[5] = 0xAAAA; with ping rd/wr pointers both at 5, assert ping_wr_en and ping_rd_en with din = 0x5555.
  - Required: dout = 0xAAAA; a later read of address 5 returns 0x5555.
- Interleaved ping-pong:
  - Stimulus: write pong while reading ping for 14 cycles, then swap roles.
  - Required: no data corruption in either bank; each bank's reads return exactly the data last written at each address.
- Reset mid-stream:
  - Stimulus: assert rst low for 1 cycle during a read burst.
  - Required: dout = 0 and dout_valid = 0 immediately; pointers = 0; after release the first read returns ping[0] (memory preserved).

Source files
------------

// File: rtl/ping_pong_row_buffer.sv
// Dual-bank (ping/pong) row buffer for the convolution datapath.
// One bank fills from the pixel stream while the other drains toward the
// window. Each bank has its own write and read pointers. The read path is
// registered, and a sticky flag records any cycle that asks for both reads.
module ping_pong_row_buffer #(
    parameter int IMAGE_SIZE = 16,
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 ping_wr_en,
    input  logic                 pong_wr_en,
    input  logic                 ping_rd_en,
    input  logic                 pong_rd_en,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_sel,
    output logic [ADDR_SIZE-1:0] ping_wr_ptr,
    output logic [ADDR_SIZE-1:0] pong_wr_ptr,
    output logic                 collision_err
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(IMAGE_SIZE - 1);

    logic [DATA_SIZE-1:0] ping_mem_q [IMAGE_SIZE];
    logic [DATA_SIZE-1:0] pong_mem_q [IMAGE_SIZE];

    logic [ADDR_SIZE-1:0] ping_wr_ptr_q, ping_wr_ptr_d;
    logic [ADDR_SIZE-1:0] pong_wr_ptr_q, pong_wr_ptr_d;
    logic [ADDR_SIZE-1:0] ping_rd_ptr_q, ping_rd_ptr_d;
    logic [ADDR_SIZE-1:0] pong_rd_ptr_q, pong_rd_ptr_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 dout_sel_q, dout_sel_d;
    logic                 collision_err_q, collision_err_d;

    // The row length need not be a power of two, so wrap on the last pixel
    // instead of relying on natural pointer overflow.
    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    // Storage is never reset, so its contents survive a reset mid-stream.
    always_ff @(posedge clk) begin
        if (ping_wr_en) ping_mem_q[ping_wr_ptr_q] <= din;
        if (pong_wr_en) pong_mem_q[pong_wr_ptr_q] <= din;
    end

    // Next-state logic for the pointers, the read register and the error flag.
    // A read samples the array before the same edge's write lands, so a
    // read-during-write returns the old word. frame_start only overrides the
    // pointer updates; data movement still uses the pre-clear pointers.
    always_comb begin
        ping_wr_ptr_d   = ping_wr_ptr_q;
        pong_wr_ptr_d   = pong_wr_ptr_q;
        ping_rd_ptr_d   = ping_rd_ptr_q;
        pong_rd_ptr_d   = pong_rd_ptr_q;
        dout_d          = dout_q;
        dout_valid_d    = 1'b0;
        dout_sel_d      = dout_sel_q;
        collision_err_d = collision_err_q;

        if (ping_wr_en) ping_wr_ptr_d = next_ptr(ping_wr_ptr_q);
        if (pong_wr_en) pong_wr_ptr_d = next_ptr(pong_wr_ptr_q);

        if (ping_rd_en) begin
            dout_d        = ping_mem_q[ping_rd_ptr_q];
            dout_sel_d    = 1'b0;
            dout_valid_d  = 1'b1;
            ping_rd_ptr_d = next_ptr(ping_rd_ptr_q);
            if (pong_rd_en) collision_err_d = 1'b1;
        end else if (pong_rd_en) begin
            dout_d        = pong_mem_q[pong_rd_ptr_q];
            dout_sel_d    = 1'b1;
            dout_valid_d  = 1'b1;
            pong_rd_ptr_d = next_ptr(pong_rd_ptr_q);
        end

        if (frame_start) begin
            ping_wr_ptr_d   = '0;
            pong_wr_ptr_d   = '0;
            ping_rd_ptr_d   = '0;
            pong_rd_ptr_d   = '0;
            collision_err_d = 1'b0;
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ping_wr_ptr_q   <= '0;
            pong_wr_ptr_q   <= '0;
            ping_rd_ptr_q   <= '0;
            pong_rd_ptr_q   <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            dout_sel_q      <= 1'b0;
            collision_err_q <= 1'b0;
        end else begin
            ping_wr_ptr_q   <= ping_wr_ptr_d;
            pong_wr_ptr_q   <= pong_wr_ptr_d;
            ping_rd_ptr_q   <= ping_rd_ptr_d;
            pong_rd_ptr_q   <= pong_rd_ptr_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            dout_sel_q      <= dout_sel_d;
            collision_err_q <= collision_err_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign dout_sel      = dout_sel_q;
    assign ping_wr_ptr   = ping_wr_ptr_q;
    assign pong_wr_ptr   = pong_wr_ptr_q;
    assign collision_err = collision_err_q;

endmodule

// File: tb/tb_ping_pong_row_buffer.sv
// Bench for ping_pong_row_buffer. A bank-level reference model (arrays plus
// modulo pointers) is checked against the DUT on every falling edge. Directed
// sequences add literal expectations that pin the model itself.
module tb_ping_pong_row_buffer;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ping_wr_en = 1'b0, pong_wr_en = 1'b0;
    logic          ping_rd_en = 1'b0, pong_rd_en = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid, dout_sel, collision_err;
    logic [AW-1:0] ping_wr_ptr, pong_wr_ptr;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = ping, 1 = pong.
    logic [DW-1:0] m_mem [2][N];
    int            m_wp [2];
    int            m_rp [2];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_sel   = 1'b0;
    logic          m_coll  = 1'b0;

    ping_pong_row_buffer #(.IMAGE_SIZE(N), .DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .din           (din),
        .ping_wr_en    (ping_wr_en),
        .pong_wr_en    (pong_wr_en),
        .ping_rd_en    (ping_rd_en),
        .pong_rd_en    (pong_rd_en),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_sel      (dout_sel),
        .ping_wr_ptr   (ping_wr_ptr),
        .pong_wr_ptr   (pong_wr_ptr),
        .collision_err (collision_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_wp[b] = 0;
            m_rp[b] = 0;
        end
        m_dout  = '0;
        m_valid = 1'b0;
        m_sel   = 1'b0;
        m_coll  = 1'b0;
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model
    // with the same inputs: reads use the array before this edge's writes.
    task automatic step(input logic fs, input logic [DW-1:0] d,
                        input logic pw, input logic qw, input logic pr, input logic qr);
        frame_start = fs; din = d;
        ping_wr_en = pw; pong_wr_en = qw; ping_rd_en = pr; pong_rd_en = qr;
        @(posedge clk);
        if (pr || qr) begin
            int b;
            b = pr ? 0 : 1;
            m_dout  = m_mem[b][m_rp[b]];
            m_sel   = (b == 1);
            m_valid = 1'b1;
            if (!fs) m_rp[b] = (m_rp[b] + 1) % N;
            if (pr && qr) m_coll = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (pw) begin
            m_mem[0][m_wp[0]] = d;
            if (!fs) m_wp[0] = (m_wp[0] + 1) % N;
        end
        if (qw) begin
            m_mem[1][m_wp[1]] = d;
            if (!fs) m_wp[1] = (m_wp[1] + 1) % N;
        end
        if (fs) begin
            for (int b2 = 0; b2 < 2; b2++) begin
                m_wp[b2] = 0;
                m_rp[b2] = 0;
            end
            m_coll = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every-cycle comparison of all observable outputs against the model.
    always @(negedge clk) begin
        chk("cyc_dout",       32'(dout),          32'(m_dout));
        chk("cyc_dout_valid", 32'(dout_valid),    32'(m_valid));
        chk("cyc_dout_sel",   32'(dout_sel),      32'(m_sel));
        chk("cyc_ping_wr_ptr",32'(ping_wr_ptr),   32'(m_wp[0]));
        chk("cyc_pong_wr_ptr",32'(pong_wr_ptr),   32'(m_wp[1]));
        chk("cyc_collision",  32'(collision_err), 32'(m_coll));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",      32'(dout),          32'h0);
        chk("rst_valid",     32'(dout_valid),    32'h0);
        chk("rst_sel",       32'(dout_sel),      32'h0);
        chk("rst_ping_wptr", 32'(ping_wr_ptr),   32'h0);
        chk("rst_pong_wptr", 32'(pong_wr_ptr),   32'h0);
        chk("rst_coll",      32'(collision_err), 32'h0);
        rst = 1'b1;
        idle();

        // Linear write then read of ping.
        for (int i = 0; i < 16; i++) step(1'b0, DW'(16'h3C00 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lin_ping_wptr_wrapped", 32'(ping_wr_ptr), 32'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("lin_dout",  32'(dout),       32'(16'h3C00 + i));
            chk("lin_valid", 32'(dout_valid), 32'h1);
            chk("lin_sel",   32'(dout_sel),   32'h0);
        end
        idle();
        chk("lin_valid_drop", 32'(dout_valid), 32'h0);
        chk("lin_dout_hold",  32'(dout),       32'h3C0F);

        // Pong wrap: 18 writes land addresses 0,1 a second time.
        for (int i = 0; i < 18; i++) step(1'b0, DW'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_pong_wptr", 32'(pong_wr_ptr), 32'h2);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_rd0", 32'(dout), 32'd16);
        chk("wrap_sel", 32'(dout_sel), 32'h1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_rd1", 32'(dout), 32'd17);

        // Collision: ping wins, pong read pointer stays at 2.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("coll_dout", 32'(dout), 32'h3C00);
        chk("coll_sel",  32'(dout_sel), 32'h0);
        chk("coll_flag", 32'(collision_err), 32'h1);
        idle(); idle();
        chk("coll_sticky", 32'(collision_err), 32'h1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("coll_pong_rptr_held", 32'(dout), 32'd2);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("coll_cleared", 32'(collision_err), 32'h0);

        // Read-during-write at ping address 5.
        for (int i = 0; i < 16; i++)
            step(1'b0, (i == 5) ? DW'(16'hAAAA) : DW'(16'h1000 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, DW'(16'h2000 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rdw_old_data", 32'(dout), 32'hAAAA);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rdw_new_data", 32'(dout), 32'h5555);

        // Interleaved: fill pong while draining ping, then swap.
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, DW'(16'h7000 + i), 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, DW'(16'h8000 + i), 1'b1, 1'b0, 1'b0, 1'b1);
            chk("ilv_pong_data", 32'(dout), 32'(16'h7000 + i));
        end
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("ilv_ping_data", 32'(dout), 32'(16'h8000 + i));
        end

        // Reset in the middle of a read burst.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_dout",  32'(dout),        32'h0);
        chk("mid_rst_valid", 32'(dout_valid),  32'h0);
        chk("mid_rst_pwptr", 32'(ping_wr_ptr), 32'h0);
        chk("mid_rst_qwptr", 32'(pong_wr_ptr), 32'h0);
        ping_rd_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        idle();
        chk("post_rst_valid", 32'(dout_valid), 32'h0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_ping0", 32'(dout), 32'h8000);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
